// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: shares one BurstRAM port between two burst-level clients.
// Whole bursts are granted round-robin. Commands, write beats and read beats
// are forwarded, and read beats are routed only to the client that owns the
// current burst.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   cN_req/cmd/addr      client N request level, 0=read/1=write, burst address
//   cN_wr_data/mask      client N write beat and byte mask (muxed to BurstRAM)
//   cN_ack               one-cycle grant pulse, coincident with br_cmd_en
//   cN_rd_data(_ready)   read beat fan-out; ready is gated to the owner
//   br_*                 BurstRAM command/data interface
//   owner, active        client holding the RAM, burst in progress
module burst_ram_arbiter #(
  parameter int unsigned DEPTH_BITWIDTH = 4,
  parameter int unsigned BURST_COUNT    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      c0_req,
  input  logic                      c0_cmd,
  input  logic [DEPTH_BITWIDTH-1:0] c0_addr,
  input  logic [63:0]               c0_wr_data,
  input  logic [7:0]                c0_data_mask,
  output logic                      c0_ack,
  output logic [63:0]               c0_rd_data,
  output logic                      c0_rd_data_ready,
  input  logic                      c1_req,
  input  logic                      c1_cmd,
  input  logic [DEPTH_BITWIDTH-1:0] c1_addr,
  input  logic [63:0]               c1_wr_data,
  input  logic [7:0]                c1_data_mask,
  output logic                      c1_ack,
  output logic [63:0]               c1_rd_data,
  output logic                      c1_rd_data_ready,
  output logic                      br_cmd,
  output logic                      br_cmd_en,
  output logic [DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]               br_wr_data,
  output logic [7:0]                br_data_mask,
  input  logic [63:0]               br_rd_data,
  input  logic                      br_rd_data_ready,
  input  logic                      br_busy,
  output logic                      owner,
  output logic                      active
);

  localparam int unsigned CNT_W = $clog2(BURST_COUNT + 1);
  // Last write beat index after ISSUE, and last read beat index.
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(BURST_COUNT - 2);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(BURST_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WR_BEATS = 2'd2,
    RD_WAIT  = 2'd3
  } state_t;

  state_t           state;
  logic             last;
  logic [CNT_W-1:0] beat_cnt;
  logic             any_req;
  logic             winner;
  logic             sel_c1;
  logic             rd_window;

  // Single request wins outright; on a tie the client that did not go last wins.
  assign any_req = c0_req | c1_req;
  assign winner  = (c0_req & c1_req) ? ~last : c1_req;

  // Burst sequencer with registered command, ack and owner outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      br_cmd_en <= 1'b0;
      br_cmd    <= 1'b0;
      br_addr   <= '0;
      c0_ack    <= 1'b0;
      c1_ack    <= 1'b0;
      owner     <= 1'b0;
      last      <= 1'b1;
      beat_cnt  <= '0;
    end else begin
      br_cmd_en <= 1'b0;
      c0_ack    <= 1'b0;
      c1_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (!br_busy && any_req) begin
            owner     <= winner;
            last      <= winner;
            br_cmd    <= winner ? c1_cmd : c0_cmd;
            br_addr   <= winner ? c1_addr : c0_addr;
            br_cmd_en <= 1'b1;
            c0_ack    <= ~winner;
            c1_ack    <= winner;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          beat_cnt <= '0;
          state    <= br_cmd ? WR_BEATS : RD_WAIT;
        end
        WR_BEATS: begin
          // Beats 1..BURST_COUNT-1 stream through without stalling.
          beat_cnt <= beat_cnt + CNT_W'(1);
          if (beat_cnt == WR_LAST) begin
            state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (br_rd_data_ready) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_cnt == RD_LAST) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write path follows the owner during a burst and parks on c0 when idle.
  assign sel_c1       = (state != IDLE) && owner;
  assign br_wr_data   = sel_c1 ? c1_wr_data : c0_wr_data;
  assign br_data_mask = sel_c1 ? c1_data_mask : c0_data_mask;

  // Read beats only count inside RD_WAIT; strays elsewhere reach nobody.
  assign rd_window        = (state == RD_WAIT) && br_rd_data_ready;
  assign c0_rd_data_ready = rd_window & ~owner;
  assign c1_rd_data_ready = rd_window & owner;
  assign c0_rd_data       = br_rd_data;
  assign c1_rd_data       = br_rd_data;

  assign active = (state != IDLE);

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Self-checking bench for burst_ram_arbiter: a table of per-cycle vectors for
// read/write bursts, plus hand sequences for ties, br_busy and mid-burst reset.
module tb_burst_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_req, c0_cmd, c1_req, c1_cmd;
  logic [3:0]  c0_addr, c1_addr;
  logic [63:0] c0_wr_data, c1_wr_data;
  logic [7:0]  c0_data_mask, c1_data_mask;
  logic        c0_ack, c1_ack, c0_rd_data_ready, c1_rd_data_ready;
  logic [63:0] c0_rd_data, c1_rd_data;
  logic        br_cmd, br_cmd_en;
  logic [3:0]  br_addr;
  logic [63:0] br_wr_data, br_rd_data;
  logic [7:0]  br_data_mask;
  logic        br_rd_data_ready, br_busy;
  logic        owner, active;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  burst_ram_arbiter #(.DEPTH_BITWIDTH(4), .BURST_COUNT(4)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_cmd(c0_cmd), .c0_addr(c0_addr), .c0_wr_data(c0_wr_data),
    .c0_data_mask(c0_data_mask), .c0_ack(c0_ack), .c0_rd_data(c0_rd_data),
    .c0_rd_data_ready(c0_rd_data_ready),
    .c1_req(c1_req), .c1_cmd(c1_cmd), .c1_addr(c1_addr), .c1_wr_data(c1_wr_data),
    .c1_data_mask(c1_data_mask), .c1_ack(c1_ack), .c1_rd_data(c1_rd_data),
    .c1_rd_data_ready(c1_rd_data_ready),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
    .br_rd_data_ready(br_rd_data_ready), .br_busy(br_busy),
    .owner(owner), .active(active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic r0; logic m0; logic [3:0] a0; logic [63:0] d0;
    logic r1; logic m1; logic [3:0] a1; logic [63:0] d1;
    logic bz; logic rdy;
    logic e_ack0; logic e_ack1; logic e_en; logic e_cmd; logic [3:0] e_addr;
    logic [63:0] e_wd; logic e_rr0; logic e_rr1; logic e_act; logic e_own;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    c0_req = 1'b0; c0_cmd = 1'b0; c0_addr = '0; c0_wr_data = '0;
    c1_req = 1'b0; c1_cmd = 1'b0; c1_addr = '0; c1_wr_data = '0;
    br_busy = 1'b0; br_rd_data_ready = 1'b0; br_rd_data = '0;
    #1;
    chk("rst_state", 64'({br_cmd_en, br_cmd, br_addr, c0_ack, c1_ack, owner, active}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits for an ack; who=0/1 for the client, 2 if both, -1 on timeout.
  task automatic wait_ack(input int budget, output int who, output int at);
    bit done;
    who = -1; at = -1; done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (c0_ack || c1_ack) begin
        who  = (c0_ack && c1_ack) ? 2 : (c1_ack ? 1 : 0);
        at   = cyc_cnt;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int who, at, at1, start;
    int gid [4];
    int gcy [4];
    int ng;
    string nm;

    c0_data_mask = 8'h0F;
    c1_data_mask = 8'hF0;

    // c0 read @3, c1 requests mid-burst, stray ready in IDLE, c1 read @7, c1 write @5.
    tbl[0]  = '{0,0,0,'hA0, 0,0,0,'hB0, 0,0,  0,0,0,0,0,'hA0, 0,0,0,0};
    tbl[1]  = '{1,0,3,'hA0, 0,0,0,'hB0, 0,0,  0,0,0,0,0,'hA0, 0,0,0,0};
    tbl[2]  = '{1,0,3,'hA0, 0,0,0,'hB0, 0,0,  1,0,1,0,3,'hA0, 0,0,1,0};
    tbl[3]  = '{0,0,0,'hA0, 0,0,0,'hB0, 0,1,  0,0,0,0,3,'hA0, 1,0,1,0};
    tbl[4]  = '{0,0,0,'hA0, 0,0,0,'hB0, 0,0,  0,0,0,0,3,'hA0, 0,0,1,0};
    tbl[5]  = '{0,0,0,'hA0, 1,0,7,'hB0, 0,1,  0,0,0,0,3,'hA0, 1,0,1,0};
    tbl[6]  = '{0,0,0,'hA0, 1,0,7,'hB0, 0,1,  0,0,0,0,3,'hA0, 1,0,1,0};
    tbl[7]  = '{0,0,0,'hA0, 1,0,7,'hB0, 0,1,  0,0,0,0,3,'hA0, 1,0,1,0};
    tbl[8]  = '{0,0,0,'hA0, 1,0,7,'hB0, 0,1,  0,0,0,0,3,'hA0, 0,0,0,0};
    tbl[9]  = '{0,0,0,'hA0, 1,0,7,'hB0, 0,0,  0,1,1,0,7,'hB0, 0,0,1,1};
    tbl[10] = '{0,0,0,'hA0, 0,0,0,'hB0, 0,1,  0,0,0,0,7,'hB0, 0,1,1,1};
    tbl[11] = '{0,0,0,'hA0, 0,0,0,'hB0, 0,1,  0,0,0,0,7,'hB0, 0,1,1,1};
    tbl[12] = '{0,0,0,'hA0, 0,0,0,'hB0, 0,1,  0,0,0,0,7,'hB0, 0,1,1,1};
    tbl[13] = '{0,0,0,'hA0, 0,0,0,'hB0, 0,1,  0,0,0,0,7,'hB0, 0,1,1,1};
    tbl[14] = '{0,0,0,'hA0, 1,1,5,'h11, 0,0,  0,0,0,0,7,'hA0, 0,0,0,1};
    tbl[15] = '{0,0,0,'hA0, 1,1,5,'h11, 0,0,  0,1,1,1,5,'h11, 0,0,1,1};
    tbl[16] = '{0,0,0,'hA0, 0,1,5,'h22, 0,0,  0,0,0,1,5,'h22, 0,0,1,1};
    tbl[17] = '{0,0,0,'hA0, 0,1,5,'h33, 0,0,  0,0,0,1,5,'h33, 0,0,1,1};
    tbl[18] = '{0,0,0,'hA0, 0,1,5,'h44, 0,0,  0,0,0,1,5,'h44, 0,0,1,1};
    tbl[19] = '{0,0,0,'hA0, 0,0,0,'h55, 0,0,  0,0,0,1,5,'hA0, 0,0,0,1};

    reset_dut();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      c0_req = tbl[i].r0; c0_cmd = tbl[i].m0; c0_addr = tbl[i].a0; c0_wr_data = tbl[i].d0;
      c1_req = tbl[i].r1; c1_cmd = tbl[i].m1; c1_addr = tbl[i].a1; c1_wr_data = tbl[i].d1;
      br_busy = tbl[i].bz; br_rd_data_ready = tbl[i].rdy;
      br_rd_data = 64'hD0 + 64'(i);
      @(negedge clk);
      nm = $sformatf("row%0d", i);
      chk({nm, "_ack0"}, 64'(c0_ack), 64'(tbl[i].e_ack0));
      chk({nm, "_ack1"}, 64'(c1_ack), 64'(tbl[i].e_ack1));
      chk({nm, "_cmd_en"}, 64'(br_cmd_en), 64'(tbl[i].e_en));
      chk({nm, "_cmd"}, 64'(br_cmd), 64'(tbl[i].e_cmd));
      chk({nm, "_addr"}, 64'(br_addr), 64'(tbl[i].e_addr));
      chk({nm, "_wr_data"}, br_wr_data, tbl[i].e_wd);
      chk({nm, "_mask"}, 64'(br_data_mask), (tbl[i].e_act && tbl[i].e_own) ? 64'hF0 : 64'h0F);
      chk({nm, "_rdy0"}, 64'(c0_rd_data_ready), 64'(tbl[i].e_rr0));
      chk({nm, "_rdy1"}, 64'(c1_rd_data_ready), 64'(tbl[i].e_rr1));
      chk({nm, "_active"}, 64'(active), 64'(tbl[i].e_act));
      chk({nm, "_owner"}, 64'(owner), 64'(tbl[i].e_own));
      chk({nm, "_rd0"}, c0_rd_data, 64'hD0 + 64'(i));
      chk({nm, "_rd1"}, c1_rd_data, 64'hD0 + 64'(i));
    end

    // Both clients hold write requests from reset: grants alternate, 5 cycles apart.
    reset_dut();
    c0_req = 1'b1; c0_cmd = 1'b1; c0_addr = 4'd1;
    c1_req = 1'b1; c1_cmd = 1'b1; c1_addr = 4'd2;
    start = cyc_cnt;
    ng = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(12, who, at);
      if (who >= 0) begin
        gid[ng] = who; gcy[ng] = at; ng++;
      end
    end
    chk("tie_grant_count", 64'(ng), 64'd4);
    for (int k = 0; k < ng; k++) begin
      chk($sformatf("tie_grant%0d_client", k), 64'(gid[k]), 64'(k % 2));
      chk($sformatf("tie_grant%0d_cycle", k), 64'(gcy[k] - start), 64'(1 + 5 * k));
    end
    c0_req = 1'b0; c1_req = 1'b0;

    // br_busy holds off the grant until the cycle after it falls.
    reset_dut();
    br_busy = 1'b1; c0_req = 1'b1; c0_cmd = 1'b0; c0_addr = 4'd9;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("busy_hold%0d", k), 64'({c0_ack, br_cmd_en}), 64'd0);
      @(posedge clk); #1;
    end
    br_busy = 1'b0;
    @(negedge clk);
    chk("busy_fall_no_ack", 64'({c0_ack, br_cmd_en}), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_after_ack", 64'({c0_ack, br_cmd_en, br_addr}), 64'({1'b1, 1'b1, 4'd9}));
    c0_req = 1'b0;

    // Reset during write beat 2 clears everything without waiting for a clock edge.
    reset_dut();
    br_rd_data_ready = 1'b1;
    c1_req = 1'b1; c1_cmd = 1'b1; c1_addr = 4'd5; c1_wr_data = 64'h11;
    wait_ack(5, who, at);
    chk("midrst_first_ack", 64'(who), 64'd1);
    c1_req = 1'b0;
    @(posedge clk); #1;
    chk("midrst_active_before", 64'(active), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_outputs", 64'({br_cmd_en, br_cmd, br_addr, c0_ack, c1_ack, owner, active,
                               c0_rd_data_ready, c1_rd_data_ready}), 64'd0);
    chk("midrst_wr_data", br_wr_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; br_rd_data_ready = 1'b0;
    c1_req = 1'b1; c1_cmd = 1'b1; c1_addr = 4'd6;
    start = cyc_cnt;
    wait_ack(5, who, at1);
    chk("postrst_c1_ack", 64'(who), 64'd1);
    chk("postrst_c1_latency", 64'(at1 - start), 64'd1);
    c0_req = 1'b1; c0_cmd = 1'b1; c0_addr = 4'd2;
    wait_ack(20, who, at);
    chk("postrst_tie_c0_wins", 64'(who), 64'd0);
    chk("postrst_tie_cycle", 64'(at - at1), 64'd5);
    c0_req = 1'b0; c1_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_ram_arbiter.md
Name: burst_ram_arbiter

Overview:
- Shares one BurstRAM port between two burst-level requesters, e.g. an instruction cache and a data cache, each with a `br_`-style command interface.
- Sits between the caches and BurstRAM.
- Grants whole bursts round-robin and forwards commands, write beats and read beats.
- Routes read beats only to the granted requester.

Parameters:
- DEPTH_BITWIDTH, 4, width of the burst address (8-byte words).
- BURST_COUNT, 4, number of 64-bit beats per burst; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- c0_req / c1_req  in  1  request level; cmd/addr/wr_data/data_mask must be held stable until the matching ack.
- c0_cmd / c1_cmd  in  1  0 = read, 1 = write.
- c0_addr / c1_addr  in  DEPTH_BITWIDTH  burst start address.
- c0_wr_data / c1_wr_data  in  64  write beat; beat 0 is present while requesting.
- c0_data_mask / c1_data_mask  in  8  passed through to BurstRAM.
- c0_ack / c1_ack  out  1  one-cycle pulse, coincident with br_cmd_en for that client.
- c0_rd_data / c1_rd_data  out  64  br_rd_data, fanned out to both clients.
- c0_rd_data_ready / c1_rd_data_ready  out  1  br_rd_data_ready gated to the owning client.
- br_cmd  out  1  to BurstRAM.
- br_cmd_en  out  1  to BurstRAM.
- br_addr  out  DEPTH_BITWIDTH  to BurstRAM.
- br_wr_data  out  64  to BurstRAM.
- br_data_mask  out  8  to BurstRAM.
- br_rd_data  in  64  from BurstRAM.
- br_rd_data_ready  in  1  from BurstRAM.
- br_busy  in  1  from BurstRAM.
- owner  out  1  client currently holding the RAM.
- active  out  1  a burst is in progress (state ≠ IDLE).

Behaviour:
- Reset values: state IDLE; br_cmd_en, br_cmd, br_addr, c*_ack, owner, active = 0; last = 1, so c0 wins the first tie; beat counter = 0.
- Reset is asynchronous. Assertion mid-burst abandons the burst immediately. No ack or ready is produced after rst rises. BurstRAM shares rst.
- br_cmd_en, br_cmd, br_addr, c*_ack and owner are registered.
- br_wr_data and br_data_mask are a combinational mux of the owner's inputs. The mux selects c0 when IDLE.
- State IDLE:
  - Arbitration happens only when br_busy = 0 and at least one request is present.
  - Only one request: that client wins.
  - Both requests: the client ≠ last wins.
  - On a win: register owner and last to the winner, load br_cmd/br_addr from the winner, and go to ISSUE.
- State ISSUE (exactly one cycle):
  - br_cmd_en = 1 and owner's ack = 1.
  - br_wr_data carries beat 0 from the owner.
  - Next state is WR_BEATS if br_cmd = 1, else RD_WAIT. Beat counter is cleared.
- State WR_BEATS:
  - The owner presents beat k on cycle ISSUE+k, for k = 1..BURST_COUNT-1. The arbiter does not stall.
  - After BURST_COUNT-1 cycles, go to IDLE.
- State RD_WAIT:
  - Each cycle with br_rd_data_ready = 1 raises the owner's rd_data_ready in the same cycle (combinational gate) and increments the counter.
  - When the BURST_COUNTth beat is seen, go to IDLE.
  - No timeout.
- The non-owner's rd_data_ready is always 0.
- br_rd_data_ready outside RD_WAIT is dropped; no client sees it.
- A request arriving during a burst waits. Ack never precedes the cycle after the current burst ends plus br_busy = 0.
- A client that drops req before ack has its request withdrawn, which is legal.
- A client that re-requests immediately after its burst loses to a waiting peer. Worst-case wait is one burst.
- Minimum latency from req (IDLE, not busy) to ack is 1 cycle.
- Back-to-back throughput:
  - Write burst: 1 + (BURST_COUNT-1) + 1 IDLE cycle.
  - Read burst: data-dependent.
- The beat counter is sized clog2(BURST_COUNT+1) and never wraps.

Test Plan:
- Reset, then c0_req read at addr 3 with br_busy = 0 → c0_ack and br_cmd_en on cycle +1, br_addr = 3, br_cmd = 0. The 4 br_rd_data_ready beats appear only on c0_rd_data_ready; c1_rd_data_ready stays 0.
- c1 write at addr 5, wr_data = 0x11, then 0x22, 0x33, 0x44 on the following cycles → br_wr_data shows 0x11..0x44 on ISSUE..ISSUE+3, after which state is IDLE.
- c0 and c1 request in the same cycle from reset → c0 granted first, c1 acked right after c0's burst completes. Repeat with both requests still held → order alternates c0, c1, c0, c1.
- br_busy held 1 for 10 cycles with c0_req high → no ack and no br_cmd_en until the cycle after br_busy falls.
- c1 requests in the middle of a c0 read burst → c1_ack only after c0's 4th ready beat. A stray br_rd_data_ready in IDLE reaches no client.
- rst asserted during WR_BEATS beat 2 → all outputs 0 asynchronously. After release, a fresh c1 request is acked normally, and a simultaneous c0 request wins because last = 1.
